// File: rtl/ccff_chain_loader.sv
// Serial loader for a ccff configuration chain: accepts bitstream words and shifts exactly CHAIN_LEN
// bits LSB first onto ccff_head. Optional parity recirculation check via CCFF_LOADER_VERIFY_EN.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 4,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned      BW    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LenC  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LastC = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WordC = CNT_W'(WORD_W);

    typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] buf_q;
    logic [BW-1:0]     buf_cnt_q;
    logic [CNT_W-1:0]  accepted_q;
    logic [CNT_W-1:0]  sent_q;

    logic              buf_full;
    logic              last_bit;
    logic              shifting;
    logic              handshake;
    logic [CNT_W-1:0]  remaining;
    logic [BW-1:0]     take;

    always_comb begin
        buf_full  = (buf_cnt_q != '0);
        last_bit  = (buf_cnt_q == BW'(1));
        shifting  = (state_q == StLoad) && buf_full;
        // Refill while the last buffered bit is leaving so words stream without a bubble
        cfg_ready = (state_q == StLoad) && (accepted_q < LenC) && (!buf_full || last_bit);
        handshake = cfg_valid && cfg_ready;
        remaining = LenC - accepted_q;
        take      = (remaining >= WordC) ? BW'(WORD_W) : remaining[BW-1:0];
        ccff_shift_en = shifting;
        ccff_head     = shifting & buf_q[0];
`ifdef CCFF_LOADER_VERIFY_EN
        if (state_q == StVerify) begin
            ccff_shift_en = 1'b1;
            ccff_head     = ccff_tail;
        end
`endif
    end

`ifdef CCFF_LOADER_VERIFY_EN
    logic parity_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            accepted_q <= '0;
            sent_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
            parity_q   <= 1'b0;
            err        <= 1'b0;
`endif
        end else if (abort) begin
            state_q   <= StIdle;
            buf_cnt_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StLoad;
                        busy       <= 1'b1;
                        buf_cnt_q  <= '0;
                        accepted_q <= '0;
                        sent_q     <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
                        parity_q   <= 1'b0;
                        err        <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (shifting) begin
                        buf_q     <= buf_q >> 1;
                        buf_cnt_q <= buf_cnt_q - BW'(1);
                        sent_q    <= sent_q + CNT_W'(1);
`ifdef CCFF_LOADER_VERIFY_EN
                        parity_q  <= parity_q ^ buf_q[0];
`endif
                    end
                    if (handshake) begin
                        buf_q      <= cfg_data;
                        buf_cnt_q  <= take;
                        accepted_q <= accepted_q + CNT_W'(take);
                    end
                    if (shifting && (sent_q == LastC)) begin
`ifdef CCFF_LOADER_VERIFY_EN
                        state_q <= StVerify;
                        sent_q  <= '0;
`else
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end
                end
`ifdef CCFF_LOADER_VERIFY_EN
                StVerify: begin
                    // Recirculate tail to head; the chain ends holding what was loaded
                    parity_q <= parity_q ^ ccff_tail;
                    sent_q   <= sent_q + CNT_W'(1);
                    if (sent_q == LastC) begin
                        if (parity_q ^ ccff_tail) begin
                            err <= 1'b1;
                        end
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 12-bit behavioural chain on head/tail.
module tb_ccff_chain_loader;
    localparam int unsigned ChainLen = 12;
    localparam int unsigned WordW    = 8;
`ifdef CCFF_LOADER_VERIFY_EN
    localparam int VerifyCyc = 12;
`else
    localparam int VerifyCyc = 0;
`endif

    logic             prog_clk = 1'b0;
    logic             pReset   = 1'b0;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic [WordW-1:0] cfg_data = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_tail;
    logic             busy;
    logic             done;
    logic             err;

    logic [ChainLen-1:0] chain = '0;
    logic                tail_flip = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[ChainLen-2:0], ccff_head};
    assign ccff_tail = chain[ChainLen-1] ^ tail_flip;

    ccff_chain_loader #(
        .CHAIN_LEN(ChainLen),
        .WORD_W   (WordW),
        .CNT_W    (16)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #2;
    endtask

    // Load 0xA5 then 0x3C; expected head sequence 1,0,1,0,0,1,0,1,0,0,1,1 (= 12'hCA5 LSB first)
    task automatic run_load(input string tag, input int stall, input int abort_at,
                            input int poke_start, input bit flip);
        int widx = 0;
        int stall_left = 0;
        int nshift = 0;
        int nstall = 0;
        int ndone = 0;
        int hs_cyc = -1;
        int done_cyc = -1;
        int vcount = 0;
        int vbad = 0;
        int late_ready = 0;
        int post_done = 0;
        bit hs;
        bit aborted = 1'b0;
        logic [11:0] got = '0;
        logic [11:0] pat;
        logic [11:0] exp_chain;
        pat = 12'hCA5;
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk({tag, ":ready_after_start"}, cfg_ready, 1'b1);
        chk({tag, ":busy_after_start"}, busy, 1'b1);
        chk({tag, ":err_after_start"}, err, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        for (int cyc = 0; cyc < 80; cyc++) begin
            hs = cfg_valid && cfg_ready;
            if (hs && hs_cyc < 0) hs_cyc = cyc;
            if (!cfg_valid && cfg_ready && stall_left > 0) stall_left--;
            if (cyc == poke_start) start = 1'b1;
            if (flip && vcount == 3) tail_flip = 1'b1;
            step();
            start = 1'b0;
            tail_flip = 1'b0;
            if (hs) begin
                widx++;
                if (widx == 1) stall_left = stall;
            end
            cfg_valid = (widx < 2) && (stall_left == 0);
            cfg_data  = (widx == 0) ? 8'hA5 : 8'h3C;
            #1;
            if (ccff_shift_en && nshift < 12) begin
                got[nshift] = ccff_head;
                nshift++;
            end else if (ccff_shift_en) begin
                vcount++;
                if (ccff_head !== ccff_tail) vbad++;
            end else if (busy && nshift > 0) begin
                nstall++;
            end
            if (widx >= 2 && cfg_ready) late_ready++;
            if (done) begin
                ndone++;
                done_cyc = cyc + 1;
            end
            if (abort_at > 0 && nshift == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (done) break;
        end
        if (aborted) begin
            abort = 1'b1;
            cfg_valid = 1'b0;
            step();
            abort = 1'b0;
            #1;
            chk({tag, ":busy_after_abort"}, busy, 1'b0);
            chk({tag, ":shift_en_after_abort"}, ccff_shift_en, 1'b0);
            chk({tag, ":ready_after_abort"}, cfg_ready, 1'b0);
            for (int k = 0; k < 4; k++) begin
                if (done) ndone++;
                step();
                #1;
            end
            chk({tag, ":no_done_on_abort"}, ndone, 0);
            return;
        end
        chk({tag, ":done_pulses"}, ndone, 1);
        chk({tag, ":busy_in_done"}, busy, 1'b0);
        chk({tag, ":head_sequence"}, got, pat);
        chk({tag, ":shift_count"}, nshift, 12);
        chk({tag, ":stall_cycles"}, nstall, stall);
        chk({tag, ":done_latency"}, done_cyc - hs_cyc, 13 + stall + VerifyCyc);
        chk({tag, ":ready_after_last_word"}, late_ready, 0);
`ifdef CCFF_LOADER_VERIFY_EN
        chk({tag, ":verify_cycles"}, vcount, 12);
        chk({tag, ":verify_head_eq_tail"}, vbad, 0);
        chk({tag, ":err_in_done"}, err, flip);
`else
        chk({tag, ":err_in_done"}, err, 1'b0);
`endif
        if (!flip) begin
            for (int i = 0; i < 12; i++) exp_chain[11-i] = pat[i];
            chk({tag, ":chain_contents"}, chain, exp_chain);
        end
        cfg_valid = 1'b0;
        step();
        #1;
        if (done) post_done++;
        chk({tag, ":done_one_cycle"}, post_done, 0);
        chk({tag, ":idle_busy"}, busy, 1'b0);
`ifdef CCFF_LOADER_VERIFY_EN
        chk({tag, ":err_sticky_idle"}, err, flip);
`endif
    endtask

    initial begin
        repeat (3) @(posedge prog_clk);
        #3;
        chk("reset:cfg_ready", cfg_ready, 1'b0);
        chk("reset:head", ccff_head, 1'b0);
        chk("reset:shift_en", ccff_shift_en, 1'b0);
        chk("reset:busy", busy, 1'b0);
        chk("reset:done", done, 1'b0);
        chk("reset:err", err, 1'b0);
        pReset = 1'b1;
        step();
        #1;

        run_load("basic", 0, 0, -1, 1'b0);
        run_load("stall", 3, 0, -1, 1'b0);
        run_load("ignored_start", 0, 0, 4, 1'b0);
`ifdef CCFF_LOADER_VERIFY_EN
        run_load("verify_flip", 0, 0, -1, 1'b1);
        run_load("verify_clean", 0, 0, -1, 1'b0);
`endif
        run_load("abort", 0, 5, -1, 1'b0);
        run_load("after_abort", 0, 0, -1, 1'b0);

        // Asynchronous reset in the middle of a load
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'hFF;
        repeat (4) step();
        #1;
        chk("midrst:shifting_before", ccff_shift_en, 1'b1);
        #2;
        pReset = 1'b0;
        #1;
        chk("midrst:cfg_ready", cfg_ready, 1'b0);
        chk("midrst:head", ccff_head, 1'b0);
        chk("midrst:shift_en", ccff_shift_en, 1'b0);
        chk("midrst:busy", busy, 1'b0);
        chk("midrst:done", done, 1'b0);
        chk("midrst:err", err, 1'b0);
        cfg_valid = 1'b0;
        step();
        pReset = 1'b1;
        step();
        #1;
        chk("postrst:cfg_ready", cfg_ready, 1'b0);
        chk("postrst:busy", busy, 1'b0);
        chk("postrst:shift_en", ccff_shift_en, 1'b0);
        run_load("post_reset", 0, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
